// File: rtl/aura_pkg.sv
// Shared attention-datapath definitions: default geometry, element/score types
// and the control states of the streaming dot-product stages.
package aura_pkg;

  localparam int DATA_W = 8;
  localparam int DIM    = 64;
  localparam int LANES  = 8;
  localparam int ACC_W  = 24;

  typedef logic signed [DATA_W-1:0] elem_t;
  typedef logic signed [ACC_W-1:0]  score_t;

  typedef enum logic [1:0] {
    LOAD_Q,
    ACCUM,
    OUT
  } state_t;

endpackage

// File: rtl/lane_dot.sv
// Combinational LANES-wide signed dot product: per-lane products reduced by a
// balanced adder tree and sign-extended to ACC_W. Shared with the P.V stage.
module lane_dot #(
  parameter int DATA_W = aura_pkg::DATA_W,
  parameter int LANES  = aura_pkg::LANES,
  parameter int ACC_W  = aura_pkg::ACC_W
) (
  input  logic [LANES*DATA_W-1:0] q_slice,
  input  logic [LANES*DATA_W-1:0] k_chunk,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [2*DATA_W-1:0] prod [LANES];
  // Heap-ordered tree: leaves at LANES-1 .. 2*LANES-2, root at index 0.
  logic signed [ACC_W-1:0]    node [2*LANES-1];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod[l] = $signed(q_slice[l*DATA_W +: DATA_W]) * $signed(k_chunk[l*DATA_W +: DATA_W]);
      node[LANES-1+l] = ACC_W'(prod[l]);
    end
    for (int i = LANES - 2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
    sum = node[0];
  end

endmodule

// File: rtl/qk_score_stage.sv
// Streaming Q.K score stage: holds one query, accumulates each key row chunk by
// chunk and hands one signed score per row to the softmax stage.
module qk_score_stage #(
  parameter int DATA_W = aura_pkg::DATA_W,
  parameter int DIM    = aura_pkg::DIM,
  parameter int LANES  = aura_pkg::LANES,
  parameter int ACC_W  = aura_pkg::ACC_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      q_vld,
  output logic                      q_rdy,
  input  logic [DIM*DATA_W-1:0]     q_data,
  input  logic                      k_vld,
  output logic                      k_rdy,
  input  logic [LANES*DATA_W-1:0]   k_data,
  input  logic                      k_end,
  output logic                      score_vld,
  input  logic                      score_rdy,
  output logic signed [ACC_W-1:0]   score_data,
  output logic                      score_end
);

  import aura_pkg::*;

  localparam int NCHUNK = DIM / LANES;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  state_t                   state, state_nxt;
  logic [DIM*DATA_W-1:0]    q_reg;
  logic [CNT_W-1:0]         cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  lane_sum;
  logic [LANES*DATA_W-1:0]  q_slice;
  logic                     q_fire, k_fire;

  assign q_slice = q_reg[int'(cnt)*LANES*DATA_W +: LANES*DATA_W];
  assign q_fire  = q_vld && q_rdy;
  assign k_fire  = k_vld && k_rdy;

  lane_dot #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .ACC_W  (ACC_W)
  ) u_lane_dot (
    .q_slice (q_slice),
    .k_chunk (k_data),
    .sum     (lane_sum)
  );

  // NOTE: every output of this block gets a default before the case, so no
  // path through it can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    q_rdy     = 1'b0;
    k_rdy     = 1'b0;
    score_vld = 1'b0;
    unique case (state)
      LOAD_Q: begin
        q_rdy = 1'b1;
        if (q_vld) state_nxt = ACCUM;
      end
      ACCUM: begin
        k_rdy = 1'b1;
        if (k_vld && cnt == LAST) state_nxt = OUT;
      end
      OUT: begin
        score_vld = 1'b1;
        // Chunk 0 of the next row may ride along with the score handoff.
        k_rdy     = score_rdy && !score_end;
        if (score_rdy) begin
          if (score_end)                   state_nxt = LOAD_Q;
          else if (NCHUNK == 1 && k_vld)   state_nxt = OUT;
          else                             state_nxt = ACCUM;
        end
      end
      default: state_nxt = LOAD_Q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD_Q;
      // NOTE: the query register is cleared too, so an aborted sequence can
      // never leak its Q into the next one.
      q_reg      <= '0;
      cnt        <= '0;
      acc        <= '0;
      score_data <= '0;
      score_end  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (q_fire) begin
        q_reg <= q_data;
        cnt   <= '0;
        acc   <= '0;
      end
      if (k_fire) begin
        if (state == ACCUM) begin
          if (cnt == LAST) begin
            score_data <= acc + lane_sum;
            score_end  <= k_end;
            cnt        <= '0;
            acc        <= '0;
          end else begin
            acc <= acc + lane_sum;
            cnt <= cnt + 1'b1;
          end
        end else if (NCHUNK == 1) begin
          score_data <= lane_sum;
          score_end  <= k_end;
        end else begin
          acc <= lane_sum;
          cnt <= CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_qk_score_stage.sv
// Directed bench for qk_score_stage: hand-computed scores, handshake timing,
// back-to-back streaming, backpressure and mid-row reset.
module tb_qk_score_stage;

  import aura_pkg::*;

  localparam int QW  = DIM * DATA_W;
  localparam int KW  = LANES * DATA_W;
  localparam int NCH = DIM / LANES;

  logic            clk = 1'b0;
  logic            rst;
  logic            q_vld, q_rdy;
  logic [QW-1:0]   q_data;
  logic            k_vld, k_rdy;
  logic [KW-1:0]   k_data;
  logic            k_end;
  logic            score_vld, score_rdy;
  score_t          score_data;
  logic            score_end;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int     k_xfer_cyc[$];
  bit     k_xfer_out[$];
  int     s_cyc[$];
  score_t s_data[$];
  bit     s_end[$];

  qk_score_stage dut (
    .clk        (clk),
    .rst        (rst),
    .q_vld      (q_vld),
    .q_rdy      (q_rdy),
    .q_data     (q_data),
    .k_vld      (k_vld),
    .k_rdy      (k_rdy),
    .k_data     (k_data),
    .k_end      (k_end),
    .score_vld  (score_vld),
    .score_rdy  (score_rdy),
    .score_data (score_data),
    .score_end  (score_end)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake monitor: inputs move just after posedge, so negedge sees the
  // values that the coming edge will transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (k_vld && k_rdy) begin
        k_xfer_cyc.push_back(cyc);
        k_xfer_out.push_back(score_vld);
      end
      if (score_vld && score_rdy) begin
        s_cyc.push_back(cyc);
        s_data.push_back(score_data);
        s_end.push_back(score_end);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [QW-1:0] fill(input int v);
    logic [QW-1:0] r;
    for (int i = 0; i < DIM; i++) r[i*DATA_W +: DATA_W] = DATA_W'(v);
    return r;
  endfunction

  task automatic clear_mon();
    k_xfer_cyc.delete();
    k_xfer_out.delete();
    s_cyc.delete();
    s_data.delete();
    s_end.delete();
  endtask

  // All drivers are entered just after a posedge and return just after one.
  task automatic put_q(input logic [QW-1:0] d);
    bit ok = 1'b0;
    q_vld  = 1'b1;
    q_data = d;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (q_rdy) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin @(posedge clk); #1; end
    q_vld = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL q_handshake: q_rdy=0 for 50 cycles, required 1");
    end
  endtask

  task automatic send_key(input logic [QW-1:0] row, input bit last, input bit drop,
                          input int n_chunks);
    for (int c = 0; c < n_chunks; c++) begin
      bit ok = 1'b0;
      k_vld  = 1'b1;
      k_data = row[c*KW +: KW];
      // Non-final chunks carry the opposite flag; the stage must ignore it.
      k_end  = (c == NCH - 1) ? last : !last;
      for (int n = 0; n < 50; n++) begin
        @(negedge clk);
        if (k_rdy) begin ok = 1'b1; break; end
        @(posedge clk); #1;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL k_handshake: chunk %0d k_rdy=0 for 50 cycles, required 1", c);
        k_vld = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    if (drop) begin
      k_vld = 1'b0;
      k_end = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    q_vld     = 1'b0;
    q_data    = '0;
    k_vld     = 1'b0;
    k_data    = '0;
    k_end     = 1'b0;
    score_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (q_rdy !== 1'b1) begin errors++; $display("FAIL reset_q_rdy: got %b, required 1", q_rdy); end
    if (k_rdy !== 1'b0) begin errors++; $display("FAIL reset_k_rdy: got %b, required 0", k_rdy); end
    if (score_vld !== 1'b0) begin errors++; $display("FAIL reset_score_vld: got %b, required 0", score_vld); end
    if (score_data !== score_t'(0)) begin errors++; $display("FAIL reset_score_data: got %0d, required 0", score_data); end
    if (score_end !== 1'b0) begin errors++; $display("FAIL reset_score_end: got %b, required 0", score_end); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    score_t expv = 128;
    score_rdy = 1'b1;
    put_q(fill(1));
    send_key(fill(2), 1'b1, 1'b1, NCH);
    @(negedge clk);
    checks += 3;
    if (score_vld !== 1'b1) begin errors++; $display("FAIL basic_latency: score_vld=%b, required 1", score_vld); end
    if (score_data !== expv) begin errors++; $display("FAIL basic_score: got %0d, required %0d", score_data, expv); end
    if (score_end !== 1'b1) begin errors++; $display("FAIL basic_end: got %b, required 1", score_end); end
    @(posedge clk); #1;
    @(negedge clk);
    checks += 3;
    if (q_rdy !== 1'b1) begin errors++; $display("FAIL basic_back_to_load: q_rdy=%b, required 1", q_rdy); end
    if (k_rdy !== 1'b0) begin errors++; $display("FAIL basic_k_rdy: got %b, required 0", k_rdy); end
    if (score_vld !== 1'b0) begin errors++; $display("FAIL basic_vld_drop: got %b, required 0", score_vld); end
    @(posedge clk); #1;
  endtask

  task automatic test_extreme();
    score_t expv = -1040384;
    put_q(fill(127));
    send_key(fill(-128), 1'b1, 1'b1, NCH);
    @(negedge clk);
    checks += 2;
    if (score_data !== expv) begin errors++; $display("FAIL extreme_score: got %h, required %h", score_data, expv); end
    if (score_end !== 1'b1) begin errors++; $display("FAIL extreme_end: got %b, required 1", score_end); end
    @(posedge clk); #1;
  endtask

  task automatic test_lane_order();
    logic [QW-1:0] ramp;
    logic [QW-1:0] sparse;
    score_t        exp_ramp = -32;
    score_t        exp_sparse = -57;
    for (int i = 0; i < DIM; i++) ramp[i*DATA_W +: DATA_W] = DATA_W'(i - 32);
    sparse = '0;
    sparse[5*DATA_W +: DATA_W]  = DATA_W'(1);
    sparse[62*DATA_W +: DATA_W] = DATA_W'(-1);
    put_q(ramp);
    send_key(fill(1), 1'b0, 1'b1, NCH);
    @(negedge clk);
    checks += 2;
    if (score_data !== exp_ramp) begin errors++; $display("FAIL lane_ramp_score: got %0d, required %0d", score_data, exp_ramp); end
    if (score_end !== 1'b0) begin errors++; $display("FAIL lane_ramp_end: got %b, required 0", score_end); end
    @(posedge clk); #1;
    // q[5]=-27 times +1 plus q[62]=30 times -1.
    send_key(sparse, 1'b1, 1'b1, NCH);
    @(negedge clk);
    checks++;
    if (score_data !== exp_sparse) begin errors++; $display("FAIL lane_sparse_score: got %0d, required %0d", score_data, exp_sparse); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    clear_mon();
    put_q(fill(1));
    send_key(fill(1), 1'b0, 1'b0, NCH);
    send_key(fill(-1), 1'b1, 1'b1, NCH);
    repeat (3) begin @(posedge clk); #1; end
    checks += 2;
    if (s_data.size() != 2) begin errors++; $display("FAIL b2b_score_count: got %0d, required 2", s_data.size()); end
    if (k_xfer_cyc.size() != 16) begin errors++; $display("FAIL b2b_k_count: got %0d, required 16", k_xfer_cyc.size()); end
    if (s_data.size() == 2) begin
      checks += 4;
      if (s_data[0] !== score_t'(64)) begin errors++; $display("FAIL b2b_score0: got %0d, required 64", s_data[0]); end
      if (s_end[0] !== 1'b0) begin errors++; $display("FAIL b2b_end0: got %b, required 0", s_end[0]); end
      if (s_data[1] !== score_t'(-64)) begin errors++; $display("FAIL b2b_score1: got %0d, required -64", s_data[1]); end
      if (s_end[1] !== 1'b1) begin errors++; $display("FAIL b2b_end1: got %b, required 1", s_end[1]); end
    end
    if (k_xfer_cyc.size() == 16 && s_cyc.size() >= 1) begin
      checks += 3;
      if (k_xfer_cyc[15] - k_xfer_cyc[0] != 15) begin errors++; $display("FAIL b2b_span: got %0d cycles, required 15", k_xfer_cyc[15] - k_xfer_cyc[0]); end
      if (k_xfer_out[8] !== 1'b1) begin errors++; $display("FAIL b2b_chunk0_in_out: score_vld=%b, required 1", k_xfer_out[8]); end
      if (s_cyc[0] != k_xfer_cyc[8]) begin errors++; $display("FAIL b2b_overlap: score cycle %0d, chunk0 cycle %0d, required equal", s_cyc[0], k_xfer_cyc[8]); end
    end
  endtask

  task automatic test_backpressure();
    logic [QW-1:0] row2;
    row2 = fill(2);
    clear_mon();
    put_q(fill(1));
    score_rdy = 1'b0;
    send_key(fill(1), 1'b0, 1'b1, NCH);
    k_vld  = 1'b1;
    k_data = row2[0 +: KW];
    k_end  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks += 3;
      if (score_vld !== 1'b1) begin errors++; $display("FAIL hold_vld%0d: got %b, required 1", i, score_vld); end
      if (score_data !== score_t'(64)) begin errors++; $display("FAIL hold_data%0d: got %0d, required 64", i, score_data); end
      if (k_rdy !== 1'b0) begin errors++; $display("FAIL hold_k_rdy%0d: got %b, required 0", i, k_rdy); end
      @(posedge clk); #1;
    end
    checks++;
    if (k_xfer_cyc.size() != 8) begin errors++; $display("FAIL hold_no_k: got %0d transfers, required 8", k_xfer_cyc.size()); end
    score_rdy = 1'b1;
    send_key(row2, 1'b1, 1'b1, NCH);
    @(negedge clk);
    checks += 2;
    if (score_data !== score_t'(128)) begin errors++; $display("FAIL release_score: got %0d, required 128", score_data); end
    if (score_end !== 1'b1) begin errors++; $display("FAIL release_end: got %b, required 1", score_end); end
    @(posedge clk); #1;
    if (k_xfer_cyc.size() == 16 && s_cyc.size() >= 1) begin
      checks += 2;
      if (s_cyc[0] != k_xfer_cyc[8]) begin errors++; $display("FAIL release_overlap: score cycle %0d, chunk0 cycle %0d, required equal", s_cyc[0], k_xfer_cyc[8]); end
      if (k_xfer_cyc[15] - k_xfer_cyc[8] != 7) begin errors++; $display("FAIL release_resume: got %0d cycles, required 7", k_xfer_cyc[15] - k_xfer_cyc[8]); end
    end else begin
      checks++;
      errors++;
      $display("FAIL release_counts: got %0d k and %0d scores, required 16 and >=1", k_xfer_cyc.size(), s_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    score_t expv = 192;
    put_q(fill(1));
    send_key(fill(5), 1'b1, 1'b1, 5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (score_vld !== 1'b0) begin errors++; $display("FAIL abort_vld: got %b, required 0", score_vld); end
    if (q_rdy !== 1'b1) begin errors++; $display("FAIL abort_q_rdy: got %b, required 1", q_rdy); end
    if (k_rdy !== 1'b0) begin errors++; $display("FAIL abort_k_rdy: got %b, required 0", k_rdy); end
    if (score_data !== score_t'(0)) begin errors++; $display("FAIL abort_data: got %0d, required 0", score_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    put_q(fill(1));
    send_key(fill(3), 1'b1, 1'b1, NCH);
    @(negedge clk);
    checks += 2;
    if (score_data !== expv) begin errors++; $display("FAIL abort_resume_score: got %0d, required %0d", score_data, expv); end
    if (score_vld !== 1'b1) begin errors++; $display("FAIL abort_resume_vld: got %b, required 1", score_vld); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extreme();
    test_lane_order();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
